// File: rtl/mel_filterbank_acc.sv
// Mel filterbank energy accumulator: bin power, overlapping triangular weighting and
// per-filter saturating accumulation, then streams NUM_FILT energies in linear or log2 form.
module mel_filterbank_acc #(
    parameter  int DATA_W   = 16,
    parameter  int NUM_FILT = 26,
    parameter  int NBINS    = 256,
    parameter  int ACC_W    = 40,
    parameter  int LOG_EN   = 0,
    localparam int OUT_W    = (LOG_EN != 0) ? 16 : ACC_W,
    localparam int AW       = $clog2(NBINS),
    localparam int IW       = $clog2(NUM_FILT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [AW-1:0]            cfg_addr,
    input  logic [IW-1:0]            cfg_idx,
    input  logic [15:0]              cfg_w,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_re,
    input  logic signed [DATA_W-1:0] s_im,
    input  logic                     s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [OUT_W-1:0]         m_data,
    output logic                     m_last,
    output logic                     err
);
    localparam int PW = 2 * DATA_W;
    localparam int KW = $clog2(NUM_FILT);

    typedef enum logic [1:0] {ACCUM, DRAIN, OUTPUT} state_t;

    state_t          state;
    logic [AW-1:0]   bin_cnt;
    logic [1:0]      drain_cnt;
    logic [KW-1:0]   k;
    logic [KW-1:0]   k_next;
    logic            accept;
    logic            frame_done;
    logic            cfg_wr_en;

    logic [IW-1:0]   tbl_idx [NBINS];
    logic [15:0]     tbl_w   [NBINS];

    logic signed [PW-1:0] re_x, im_x, re_sq, im_sq;
    logic [PW-1:0]   p_next;
    logic            v1, v2;
    logic [PW-1:0]   p1, r2, f2;
    logic [IW-1:0]   idx1, idx2;
    logic [15:0]     w1;
    logic [16:0]     wf;
    logic [PW+16:0]  prod_r, prod_f;
    logic [PW-1:0]   add_v [NUM_FILT];
    logic [ACC_W-1:0] acc [NUM_FILT];

    assign s_ready    = (state == ACCUM) && !rst;
    assign accept     = s_valid && s_ready;
    assign k_next     = k + KW'(1);
    assign frame_done = (state == OUTPUT) && m_ready && (k == KW'(NUM_FILT - 1));
    assign cfg_wr_en  = cfg_we && (state == ACCUM) && (bin_cnt == '0);

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [PW-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W + 1)'(b);
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    // Log form: leading-one position, then the 10 bits under it (left-aligned, so short values pad with zeros).
    function automatic logic [OUT_W-1:0] fmt(input logic [ACC_W-1:0] x);
        logic [5:0]       e;
        logic [ACC_W-1:0] n_sh;
        logic [15:0]      lv;
        e = '0;
        for (int i = 0; i < ACC_W; i++)
            if (x[i]) e = 6'(i);
        n_sh = x << (ACC_W - 1 - int'(e));
        lv   = (x > ACC_W'(1)) ? {e, 10'(n_sh >> (ACC_W - 11))} : '0;
        return (LOG_EN != 0) ? OUT_W'(lv) : OUT_W'(x);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the weight table is cleared on reset on purpose; a reset must discard any loaded weights.
            for (int i = 0; i < NBINS; i++) begin
                tbl_idx[i] <= '0;
                tbl_w[i]   <= '0;
            end
        end else if (cfg_wr_en) begin
            tbl_idx[cfg_addr] <= cfg_idx;
            tbl_w[cfg_addr]   <= (cfg_w > 16'd32768) ? 16'd32768 : cfg_w;
        end
    end

    always_comb begin
        re_x   = PW'(s_re);
        im_x   = PW'(s_im);
        re_sq  = re_x * re_x;
        im_sq  = im_x * im_x;
        p_next = $unsigned(re_sq) + $unsigned(im_sq);
        wf     = 17'd32768 - {1'b0, w1};
        prod_r = (PW + 17)'(p1) * (PW + 17)'(w1);
        prod_f = (PW + 17)'(p1) * (PW + 17)'(wf);
    end

    // Stage 1 power + table lookup, stage 2 rising/falling weighting.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0; p1 <= '0; idx1 <= '0; w1 <= '0;
            v2 <= 1'b0; r2 <= '0; f2 <= '0; idx2 <= '0;
        end else begin
            v1   <= accept;
            p1   <= p_next;
            idx1 <= tbl_idx[bin_cnt];
            w1   <= tbl_w[bin_cnt];
            v2   <= v1;
            r2   <= PW'(prod_r >> 15);
            f2   <= PW'(prod_f >> 15);
            idx2 <= idx1;
        end
    end

    // The rising and falling terms always target adjacent filters, so each filter gets at most one.
    always_comb begin
        for (int f = 0; f < NUM_FILT; f++) begin
            add_v[f] = '0;
            if (v2) begin
                if (int'(idx2) == f)          add_v[f] = r2;
                else if (int'(idx2) == f + 1) add_v[f] = f2;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int f = 0; f < NUM_FILT; f++) begin
            if (rst || frame_done) acc[f] <= '0;
            else                   acc[f] <= sat_add(acc[f], add_v[f]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            bin_cnt   <= '0;
            drain_cnt <= '0;
            k         <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                ACCUM: if (accept) begin
                    bin_cnt <= bin_cnt + AW'(1);
                    if (bin_cnt == AW'(NBINS - 1) && !s_last) err <= 1'b1;
                    if (s_last || bin_cnt == AW'(NBINS - 1)) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 2'd1;
                    if (drain_cnt == 2'd2) begin
                        state   <= OUTPUT;
                        k       <= '0;
                        m_valid <= 1'b1;
                        m_data  <= fmt(acc[0]);
                        m_last  <= (NUM_FILT == 1);
                    end
                end
                OUTPUT: if (m_ready) begin
                    if (k == KW'(NUM_FILT - 1)) begin
                        state   <= ACCUM;
                        bin_cnt <= '0;
                        k       <= '0;
                        m_valid <= 1'b0;
                        m_data  <= '0;
                        m_last  <= 1'b0;
                    end else begin
                        k      <= k_next;
                        m_data <= fmt(acc[k_next]);
                        m_last <= (k_next == KW'(NUM_FILT - 1));
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_mel_filterbank_acc.sv
// Bench for mel_filterbank_acc: a linear (ACC_W=32) and a log (ACC_W=40) instance share stimulus
// and are checked against a bench-side filterbank model through an expected-result queue.
module tb_mel_filterbank_acc;
    localparam int NF = 26;
    localparam int NB = 256;

    typedef struct packed {
        logic [31:0] lin;
        logic [15:0] lg;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_addr = '0;
    logic [4:0]  cfg_idx = '0;
    logic [15:0] cfg_w = '0;
    logic        s_valid = 1'b0;
    logic signed [15:0] s_re = '0, s_im = '0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b1;

    logic        s_ready_a, m_valid_a, m_last_a, err_a;
    logic [31:0] m_data_a;
    logic        s_ready_b, m_valid_b, m_last_b, err_b;
    logic [15:0] m_data_b;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t            exp_q[$];
    int unsigned     tbl_idx_m [NB];
    int unsigned     tbl_w_m   [NB];
    logic signed [15:0] re_arr [NB];
    logic signed [15:0] im_arr [NB];
    bit              err_exp;

    always #5 clk = ~clk;

    mel_filterbank_acc #(.DATA_W(16), .NUM_FILT(NF), .NBINS(NB), .ACC_W(32), .LOG_EN(0)) dut_lin (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_idx(cfg_idx), .cfg_w(cfg_w),
        .s_valid(s_valid), .s_ready(s_ready_a), .s_re(s_re), .s_im(s_im), .s_last(s_last),
        .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a), .m_last(m_last_a), .err(err_a));

    mel_filterbank_acc #(.DATA_W(16), .NUM_FILT(NF), .NBINS(NB), .ACC_W(40), .LOG_EN(1)) dut_log (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_idx(cfg_idx), .cfg_w(cfg_w),
        .s_valid(s_valid), .s_ready(s_ready_b), .s_re(s_re), .s_im(s_im), .s_last(s_last),
        .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .m_last(m_last_b), .err(err_b));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint unsigned sat(input longint unsigned x, input int w);
        longint unsigned mx;
        mx = (64'd1 << w) - 64'd1;
        return (x > mx) ? mx : x;
    endfunction

    function automatic logic [15:0] log_ref(input longint unsigned x);
        int e;
        longint unsigned f;
        if (x <= 1) return 16'd0;
        e = 63;
        while (x[e] == 1'b0) e--;
        if (e >= 10) f = (x >> (e - 10)) & 64'd1023;
        else         f = (x << (10 - e)) & 64'd1023;
        return {6'(e), 10'(f)};
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; cfg_we = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        check("rst_s_ready_lin", s_ready_a, 0);
        check("rst_s_ready_log", s_ready_b, 0);
        check("rst_m_valid", {m_valid_a, m_valid_b}, 0);
        check("rst_m_data_lin", m_data_a, 0);
        check("rst_m_data_log", m_data_b, 0);
        check("rst_m_last", {m_last_a, m_last_b}, 0);
        check("rst_err", {err_a, err_b}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", {s_ready_a, s_ready_b}, 2'b11);
        for (int i = 0; i < NB; i++) begin
            tbl_idx_m[i] = 0;
            tbl_w_m[i]   = 0;
        end
        err_exp = 1'b0;
        exp_q.delete();
    endtask

    task automatic cfg_write(input int addr, input int idx, input int w, input bit apply);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 8'(addr); cfg_idx = 5'(idx); cfg_w = 16'(w);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        if (apply) begin
            tbl_idx_m[addr] = idx;
            tbl_w_m[addr]   = (w > 32768) ? 32768 : w;
        end
    endtask

    task automatic send_frame(input int n, input bit last_on_final, input int mid_cfg_at);
        longint unsigned acc_m [NF];
        longint          re_l, im_l;
        longint unsigned p, r, f;
        int unsigned     idx, w;
        int              stalls;
        exp_t            e;
        stalls = 0;
        for (int k = 0; k < NF; k++) acc_m[k] = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!s_ready_a) stalls++;
            s_valid  = 1'b1;
            s_re     = re_arr[i];
            s_im     = im_arr[i];
            s_last   = last_on_final && (i == n - 1);
            cfg_we   = (i == mid_cfg_at);
            cfg_addr = 8'd5; cfg_idx = 5'd3; cfg_w = 16'd1000;
            re_l = longint'(re_arr[i]);
            im_l = longint'(im_arr[i]);
            p    = longint'(re_l * re_l + im_l * im_l);
            idx  = tbl_idx_m[i];
            w    = tbl_w_m[i];
            r    = (p * w) >> 15;
            f    = (p * (32768 - w)) >> 15;
            if (idx < NF) acc_m[idx] += r;
            if (idx >= 1 && idx <= NF) acc_m[idx - 1] += f;
            if (i == NB - 1 && !s_last) err_exp = 1'b1;
        end
        @(posedge clk);
        #1 s_valid = 1'b0; s_last = 1'b0; cfg_we = 1'b0;
        check("s_ready_in_frame", stalls, 0);
        for (int k = 0; k < NF; k++) begin
            e.lin  = 32'(sat(acc_m[k], 32));
            e.lg   = log_ref(sat(acc_m[k], 40));
            e.last = (k == NF - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input int stall_k, input int stall_len, input int stop_after, input bit hold_valid);
        int k, stall, waited, budget;
        bit first;
        logic [31:0] held_a;
        logic [15:0] held_b;
        exp_t e;
        k = 0; stall = 0; waited = 0; budget = 0; first = 1'b1;
        held_a = '0; held_b = '0;
        s_valid = hold_valid;
        m_ready = 1'b1;
        while (k < stop_after && budget < 300) begin
            @(negedge clk);
            budget++;
            check("valid_match", m_valid_b, m_valid_a);
            if (!m_valid_a) begin
                if (k > 0) check("m_valid_gap", m_valid_a, 1);
                waited++;
                m_ready = 1'b1;
            end else begin
                if (first) begin
                    check("first_out_latency", waited + 1, 4);
                    first = 1'b0;
                end
                check("s_ready_out", {s_ready_a, s_ready_b}, 0);
                if (k == stall_k && stall < stall_len) begin
                    m_ready = 1'b0;
                    if (stall == 0) begin
                        held_a = m_data_a;
                        held_b = m_data_b;
                    end else begin
                        check("hold_lin", m_data_a, held_a);
                        check("hold_log", m_data_b, held_b);
                    end
                    stall++;
                end else begin
                    m_ready = 1'b1;
                    check("q_nonempty", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check($sformatf("lin_k%0d", k), m_data_a, e.lin);
                        check($sformatf("log_k%0d", k), m_data_b, e.lg);
                        check($sformatf("last_k%0d", k), {m_last_a, m_last_b}, {e.last, e.last});
                    end
                    k++;
                end
            end
        end
        if (k < stop_after) check("drain_timeout", k, stop_after);
        if (k == NF) begin
            @(negedge clk);
            s_valid = 1'b0;
            check("resume_s_ready", {s_ready_a, s_ready_b}, 2'b11);
            check("resume_m_valid", {m_valid_a, m_valid_b}, 0);
            check("err_lin", err_a, err_exp);
            check("err_log", err_b, err_exp);
        end
    endtask

    initial begin
        reset_dut();

        // Triangle: two half-weight bins straddling filters 0 and 1.
        cfg_write(1, 0, 16384, 1);
        cfg_write(2, 1, 16384, 1);
        for (int i = 0; i < 4; i++) begin
            re_arr[i] = 16'sd4;
            im_arr[i] = 16'sd0;
        end
        send_frame(4, 1'b1, -1);
        drain(-1, 0, NF, 1'b0);

        // Random weights (with an over-range weight), random bins, backpressure at k=2.
        for (int a = 4; a < 40; a++) cfg_write(a, int'($urandom_range(0, NF)), int'($urandom_range(0, 40000)), 1);
        cfg_write(7, 2, 65535, 1);
        for (int i = 0; i < 40; i++) begin
            re_arr[i] = 16'($urandom);
            im_arr[i] = 16'($urandom);
        end
        send_frame(40, 1'b1, -1);
        drain(2, 5, NF, 1'b1);

        // Same frame again with a mid-frame write that must be ignored.
        send_frame(40, 1'b1, 10);
        drain(-1, 0, NF, 1'b0);

        // Log format on a single full-weight bin.
        reset_dut();
        cfg_write(0, 0, 32768, 1);
        re_arr[0] = 16'sd32767;
        im_arr[0] = 16'sd32767;
        send_frame(1, 1'b1, -1);
        drain(-1, 0, NF, 1'b0);

        // Reset during output, then a frame against the cleared table.
        for (int i = 0; i < 6; i++) begin
            re_arr[i] = 16'($urandom);
            im_arr[i] = 16'($urandom);
        end
        send_frame(6, 1'b1, -1);
        drain(-1, 0, 3, 1'b0);
        reset_dut();
        send_frame(6, 1'b1, -1);
        drain(-1, 0, NF, 1'b0);

        // Saturation and frame-length error: NBINS max-power bins, no s_last.
        for (int a = 0; a < NB; a++) cfg_write(a, 0, 32768, 1);
        for (int i = 0; i < NB; i++) begin
            re_arr[i] = -16'sd32768;
            im_arr[i] = -16'sd32768;
        end
        send_frame(NB, 1'b0, -1);
        drain(-1, 0, NF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mel_filterbank_acc.md
# mel_filterbank_acc

Streaming, parametrised Mel filterbank energy accumulator for the MFCC feature path. It accepts one complex FFT bin per cycle over a valid/ready stream, computes bin power, and applies run-time-loadable overlapping triangular weights. It accumulates NUM_FILT filter energies per frame, then streams them out in linear or log2 form to the DCT/cepstrum stage.

## Interface
- DATA_W, 16: signed width of each real/imag input.
- NUM_FILT, 26: number of Mel filters (≥2).
- NBINS, 256: maximum bins per frame; also the weight-table depth.
- ACC_W, 40: accumulator width; ≥2*DATA_W.
- LOG_EN, 0: 1 = log2 output format, 0 = linear.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cfg_we  in  1  weight-table write strobe.
- cfg_addr  in  $clog2(NBINS)  bin index to write.
- cfg_idx  in  $clog2(NUM_FILT+1)  rising-filter index for that bin.
- cfg_w  in  16  rising weight, unsigned Q1.15, 0..32768.
- s_valid  in  1  input bin valid.
- s_ready  out  1  block accepts a bin.
- s_re, s_im  in  DATA_W each  signed bin components.
- s_last  in  1  final bin of the frame.
- m_valid  out  1  filter energy valid.
- m_ready  in  1  downstream accepts.
- m_data  out  OUT_W  energy; OUT_W = LOG_EN ? 16 : ACC_W.
- m_last  out  1  marks filter NUM_FILT-1.
- err  out  1  sticky frame-length error.

## Operation
- Weight table: NBINS entries of {idx, w}. All entries reset to {0, 0}.
- A write is performed only when cfg_we=1 and the state is ACCUM with bin counter 0. Otherwise the write is ignored.
- A cfg_w value above 32768 is clamped to 32768 on write.
- Per accepted bin b:
  - P = re²+im², unsigned, 2*DATA_W bits (max 2^(2*DATA_W-1)).
  - Rising term R = (P*w)>>15. Falling term F = (P*(32768-w))>>15. Both use floor.
  - R is added to acc[idx] if idx<NUM_FILT.
  - F is added to acc[idx-1] if idx≥1.
  - idx=0 with w=0 contributes nothing, so bins outside all filters are encoded as {0, 0}.
- Accumulators: NUM_FILT × ACC_W, unsigned, saturating at all-ones and never wrapping. Two updates to different filters in one cycle are both applied.
- State machine:
  - ACCUM: s_ready=1. The bin counter increments per accepted bin.
  - ACCUM → DRAIN: on acceptance of a bin with s_last=1, or of bin NBINS-1.
  - DRAIN: s_ready=0 while the pipeline empties (3 cycles).
  - DRAIN → OUTPUT: after the drain cycles.
  - OUTPUT: s_ready=0. m_data presents filter k, starting at k=0. k advances on m_valid&&m_ready.
  - OUTPUT → ACCUM: on the handshake of k=NUM_FILT-1. In that same cycle all accumulators and the bin counter clear.
- err is set when bin NBINS-1 is accepted with s_last=0. Frame processing completes normally. err clears only on rst.
- Log mode, x = acc[k]:
  - x=0 or x=1 → 0.
  - Otherwise m_data = {e[5:0], f[9:0]}, where e = position of the leading one.
  - f = the 10 bits directly below the leading one: zero-padded on the right if fewer exist, truncated otherwise.
- Linear mode: m_data = acc[k].
- Reset:
  - state ACCUM, counter 0, accumulators and pipeline cleared, table zeroed.
  - s_ready=0 during rst, 1 in the first cycle after.
  - m_valid=0, m_data=0, m_last=0, err=0.
  - Reset mid-frame or mid-output discards all partial results and the table.

## Timing
- Throughput: 1 bin/cycle in ACCUM.
- Pipeline: power (stage 1), weighting (stage 2), accumulate (stage 3).
- Last bin accepted in cycle T → accumulators final at end of T+3 → m_valid=1 from cycle T+4.
- m_data, m_last and m_valid are registered.
- m_data holds stable while m_valid=1 and m_ready=0.
- A full-rate drain gives NUM_FILT consecutive output cycles.
- After the final output handshake in cycle U, s_ready=1 in cycle U+1.
- s_valid while s_ready=0 is not consumed and causes no state change.

## Test plan
- Linear mode, triangle shape:
  - Table: bin1 {0, 16384}, bin2 {1, 16384}; all others {0, 0}.
  - Frame: bins 0..3 with re=4, im=0, last on bin 3.
  - Expect acc0 = 8 + 8 = 16 and acc1 = 8; other filters 0; m_last on filter NUM_FILT-1; err=0.
- Log mode:
  - Drive a single bin with idx=0, w=32768, re=im=32767 (P=2147352578).
  - Expect filter 0 output = {6'd30, 10'd1023}, with f taken as the 10 bits below bit 30. All other filters output 0.
- Backpressure:
  - Hold m_ready=0 for 5 cycles at k=2, with s_valid held high throughout.
  - Expect m_data stable, no bin consumed, and frame resumption only after the last handshake.
- Saturation:
  - ACC_W=2*DATA_W.
  - Send NBINS max-power bins, all mapped to filter 0 with w=32768.
  - Expect acc0 = all-ones and err=1.
- Config gating and reset:
  - A cfg write mid-frame is ignored; verified by rerunning the frame and getting the same outputs.
  - Assert rst during OUTPUT: all outputs read 0, s_ready returns 1 on the next cycle, and a subsequent frame yields zero energies (table cleared).
